// File: rtl/adder_pkg.sv
// Shared constants, stage-count helper and per-stage control record for adder_pipe.
// The wide sum/operand fields of a stage live beside this record as plain vectors sized by WIDTH.
package adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
    } stage_ctl_t;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One CHUNK-bit slice of the pipelined adder: adds slice IDX plus the incoming carry and
// registers valid, carry, sub flag, the partial sum and the operands for later slices.
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  stage_ctl_t       i_ctl,
    input  logic [WIDTH-1:0] i_sum,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output stage_ctl_t       o_ctl,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b
);

    localparam int LSB = IDX * CHUNK;

    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK:0]   w_add;

    stage_ctl_t       r_ctl;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    // Subtraction inverts B slice by slice; the +1 arrives as stage 0's carry-in.
    assign w_a_sl = i_a[LSB +: CHUNK];
    assign w_b_sl = i_b[LSB +: CHUNK] ^ {CHUNK{i_ctl.sub}};
    assign w_add  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, i_ctl.carry};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctl <= '0;
            r_sum <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (i_en) begin
            r_ctl.valid           <= i_ctl.valid;
            r_ctl.carry           <= w_add[CHUNK];
            r_ctl.sub             <= i_ctl.sub;
            r_sum                 <= i_sum;
            r_sum[LSB +: CHUNK]   <= w_add[CHUNK-1:0];
            r_a                   <= i_a;
            r_b                   <= i_b;
        end
    end

    assign o_ctl = r_ctl;
    assign o_sum = r_sum;
    assign o_a   = r_a;
    assign o_b   = r_b;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder, one CHUNK-bit slice per stage, valid/ready with global stall.
// Optional subtract (sub port, a + ~b + 1) enabled by defining ADDER_SUB_EN.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    logic             w_stall;
    logic             w_sub;
    logic             w_b_msb;
    logic             w_unused;
    stage_ctl_t       w_ctl_in;
    stage_ctl_t       w_ctl [0:LAST];
    logic [WIDTH-1:0] w_sum [0:LAST];
    logic [WIDTH-1:0] w_a   [0:LAST];
    logic [WIDTH-1:0] w_b   [0:LAST];

`ifdef ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // A held result freezes every stage at once; bubbles are not squeezed out.
    assign w_stall  = w_ctl[LAST].valid && !out_ready;
    assign in_ready = rst_n && !w_stall;

    assign w_ctl_in = '{valid: in_valid && in_ready, carry: w_sub | ci, sub: w_sub};

    for (genvar g_k = 0; g_k < STAGES; g_k++) begin : g_stage
        if (g_k == 0) begin : g_first
            adder_pipe_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(g_k)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .i_en  (!w_stall),
                .i_ctl (w_ctl_in),
                .i_sum ('0),
                .i_a   (a),
                .i_b   (b),
                .o_ctl (w_ctl[g_k]),
                .o_sum (w_sum[g_k]),
                .o_a   (w_a[g_k]),
                .o_b   (w_b[g_k])
            );
        end else begin : g_next
            adder_pipe_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(g_k)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .i_en  (!w_stall),
                .i_ctl (w_ctl[g_k-1]),
                .i_sum (w_sum[g_k-1]),
                .i_a   (w_a[g_k-1]),
                .i_b   (w_b[g_k-1]),
                .o_ctl (w_ctl[g_k]),
                .o_sum (w_sum[g_k]),
                .o_a   (w_a[g_k]),
                .o_b   (w_b[g_k])
            );
        end
    end

    assign out_valid = w_ctl[LAST].valid;
    assign s         = w_sum[LAST];
    assign co        = w_ctl[LAST].carry;

    // Overflow judged against the effective B, i.e. ~b when subtracting.
    assign w_b_msb = w_b[LAST][WIDTH-1] ^ w_ctl[LAST].sub;
    assign ov      = (w_a[LAST][WIDTH-1] == w_b_msb) && (s[WIDTH-1] != w_a[LAST][WIDTH-1]);

    assign w_unused = ^{w_a[LAST][WIDTH-2:0], w_b[LAST][WIDTH-2:0]};

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH=32, CHUNK=8): directed corner cases plus
// randomized traffic with backpressure and mid-flight resets against an arithmetic model.
module tb_adder_pipe;

    localparam int W   = 32;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ci;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          co;
    logic          ov;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_acc = 0;
    int n_out = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   last_stall = -1000;
    bit   rst_prev   = 1'b0;

    adder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ov        (ov)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Plain integer arithmetic: add is a+b+ci, subtract is a-b with co = no borrow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic sb);
        exp_t        e;
        logic [63:0] u;
        longint      sx;
        longint      sy;
        longint      r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sb) begin
            u    = 64'(x) - 64'(y);
            e.co = (x >= y);
            r    = sx - sy;
        end else begin
            u    = 64'(x) + 64'(y) + 64'(c);
            e.co = u[W];
            r    = sx + sy + longint'(c);
        end
        e.s   = u[W-1:0];
        e.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.acc = 0;
        return e;
    endfunction

    // Per-cycle checker: reset values, ready rule, result order/values and latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst_prev) begin
            chk("rst_out_valid", 64'(out_valid), 0);
            chk("rst_s", 64'(s), 0);
            chk("rst_co", 64'(co), 0);
            chk("rst_ov", 64'(ov), 0);
        end
        if (!rst_n) begin
            chk("rst_in_ready", 64'(in_ready), 0);
            q.delete();
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid) begin
                chk("orphan_result", 64'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    chk("s", 64'(s), 64'(q[0].s));
                    chk("co", 64'(co), 64'(q[0].co));
                    chk("ov", 64'(ov), 64'(q[0].ov));
                    if (last_stall < q[0].acc)
                        chk("latency", 64'(cyc - q[0].acc), LAT);
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end else if (q.size() != 0 && last_stall < q[0].acc && cyc - q[0].acc >= LAT) begin
                chk("missing_result", 64'(out_valid), 1);
            end
            if (out_valid && !out_ready) last_stall = cyc;
            if (in_valid && in_ready) begin
                e     = model(a, b, ci, sub);
                e.acc = cyc;
                q.push_back(e);
                n_acc++;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic c, input logic sb, output int acc);
        in_valid = 1'b1;
        a = aa; b = bb; ci = c; sub = sb;
        acc = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        chk("send_accept", 64'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] es, input logic eco,
                              input logic eov, input int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 64'(cyc - acc), LAT);
        chk({nm, "_s"}, 64'(s), 64'(es));
        chk({nm, "_co"}, 64'(co), 64'(eco));
        chk({nm, "_ov"}, 64'(ov), 64'(eov));
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   acc;
        int   acc0;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;

        e = model(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        chk("pin_carry_all", {31'b0, e.co, e.ov, e.s}, {31'b0, 1'b1, 1'b0, 32'h0});
        e = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("pin_pos_ovf", {31'b0, e.co, e.ov, e.s}, {31'b0, 1'b0, 1'b1, 32'h8000_0000});
        e = model(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        chk("pin_neg_ovf", {31'b0, e.co, e.ov, e.s}, {31'b0, 1'b1, 1'b1, 32'h0});
        e = model(32'd5, 32'd7, 1'b0, 1'b1);
        chk("pin_sub_borrow", {31'b0, e.co, e.ov, e.s}, {31'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        e = model(32'd7, 32'd5, 1'b1, 1'b1);
        chk("pin_sub_noborrow", {31'b0, e.co, e.ov, e.s}, {31'b0, 1'b1, 1'b0, 32'h2});

        tick(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(in_ready), 1);
        @(posedge clk); #1;

        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, acc);
        expect_out("ripple", 32'h0, 1'b1, 1'b0, acc);
        @(posedge clk); #1;
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, acc);
        expect_out("pos_ovf", 32'h8000_0000, 1'b0, 1'b1, acc);
        @(posedge clk); #1;
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, acc);
        expect_out("neg_ovf", 32'h0, 1'b1, 1'b1, acc);
        @(posedge clk); #1;
`ifdef ADDER_SUB_EN
        send(32'd5, 32'd7, 1'b0, 1'b1, acc);
        expect_out("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, acc);
        @(posedge clk); #1;
        send(32'd7, 32'd5, 1'b0, 1'b1, acc);
        expect_out("sub_noborrow", 32'h2, 1'b1, 1'b0, acc);
        @(posedge clk); #1;
`endif
        tick(2);

        // Eight back-to-back operations; the checker pins each one to LAT cycles.
        acc0 = n_out;
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'b0, acc);
        tick(LAT + 2);
        chk("b2b_delivered", 64'(n_out - acc0), 8);

        // Consumer stalls for six cycles while the producer keeps offering.
        acc0 = n_acc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom);
            tick(1);
        end
        in_valid = 1'b0;
        chk("stall_accepted", 64'(n_acc - acc0), 4);
        chk("stall_in_ready", 64'(in_ready), 0);
        out_ready = 1'b1;
        tick(LAT + 4);
        chk("stall_drained", 64'(q.size()), 0);

        // Reset with three operations in flight; none may surface afterwards.
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom), 1'b0, acc);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(LAT + 4);

        // Randomized traffic with backpressure and occasional resets.
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            a         = rand_op();
            b         = rand_op();
            ci        = 1'($urandom);
`ifdef ADDER_SUB_EN
            sub       = 1'($urandom);
`else
            sub       = 1'b0;
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 149) != 0);
            tick(1);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick(LAT + 6);
        chk("final_drained", 64'(q.size()), 0);
        chk("final_idle", 64'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
